// File: rtl/fft_ctrl_if.sv
// Control bundle between the 32-point SDF FFT sequencer, its sample source and
// the datapath/sorter. The source drives in_valid; the controller drives the rest.
interface fft_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic        pipe_en;
  logic [4:0]  bf_sel;
  logic [19:0] tw_idx;
  logic        out_valid;
  logic        start_sorting;
  logic        frame_done;
  logic        busy;

  modport master (
    output in_valid,
    input  in_ready, pipe_en, bf_sel, tw_idx, out_valid, start_sorting, frame_done, busy
  );

  modport slave (
    input  in_valid,
    output in_ready, pipe_en, bf_sel, tw_idx, out_valid, start_sorting, frame_done, busy
  );
endinterface

// File: rtl/fft_ctrl.sv
// Sequencer for the 32-point radix-2 SDF FFT: pipeline advance, stage mode selects,
// twiddle indices and output strobes. Define FFT_CTRL_FLUSH_EN to enable pipeline flush.
//
//   state | meaning
//   IDLE  | pipeline empty, cnt == 0, waiting for the first sample of a frame
//   RUN   | accepting samples; stalls on in_valid low
//   FLUSH | pushing bubble frames to drain the pipeline (FFT_CTRL_FLUSH_EN only)
module fft_ctrl #(
  parameter int STAGE_LAT = 0
) (
  input logic       clk,
  input logic       rst,
  fft_ctrl_if.slave bus
);
  localparam int LAT = 31 + 5 * STAGE_LAT;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [4:0]     cnt;
  logic [4:0]     ocnt;
  logic [LAT-1:0] vld;
  logic           in_ready;
  logic           accept;
  logic           adv;
  logic           out_valid;
  logic           cnt_zero;
  logic           vld_any;
  logic [4:0]     bf_sel;
  logic [19:0]    tw_idx;

  assign cnt_zero = (cnt == 5'd0);
  assign vld_any  = |vld;

`ifdef FFT_CTRL_FLUSH_EN
  assign in_ready = !((state == FLUSH) && !cnt_zero);
`else
  assign in_ready = 1'b1;
`endif
  assign accept = bus.in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // The first bubble of a flush is issued in the same cycle RUN decides to flush,
  // and a drained FLUSH leaves at cnt == 0 without advancing, so IDLE keeps cnt == 0.
  always_comb begin
    state_nxt = state;
    adv       = accept;
    case (state)
      IDLE: begin
        if (accept) state_nxt = RUN;
      end
      RUN: begin
        if (cnt_zero && !accept) begin
          if (!vld_any) state_nxt = IDLE;
`ifdef FFT_CTRL_FLUSH_EN
          else begin
            state_nxt = FLUSH;
            adv       = 1'b1;
          end
`endif
        end
      end
`ifdef FFT_CTRL_FLUSH_EN
      FLUSH: begin
        if (!cnt_zero) begin
          adv = 1'b1;
        end else if (accept) begin
          state_nxt = RUN;
        end else if (vld_any) begin
          adv = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  assign out_valid = adv & vld[LAT-1];

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt  <= 5'd0;
      ocnt <= 5'd0;
      vld  <= '0;
    end else begin
      if (adv) begin
        cnt <= cnt + 5'd1;
        vld <= {vld[LAT-2:0], accept};
      end
      if (out_valid) ocnt <= ocnt + 5'd1;
    end
  end

  // Stage s sees the frame delayed by off_s; only the low 5-s bits of its local
  // position matter (mode bit on top, twiddle bits below).
  for (genvar s = 0; s < 5; s++) begin : g_stage
    localparam logic [4:0] OFF = 5'((32 - (32 >> s) + s * STAGE_LAT) % 32);
    localparam int W = 5 - s;
    logic [W-1:0] c;

    assign c         = W'(cnt - OFF);
    assign bf_sel[s] = c[W-1];

    if (s < 4) begin : g_tw
      assign tw_idx[4*s +: 4] = c[W-1] ? 4'd0 : (4'(c[W-2:0]) << s);
    end else begin : g_tw_last
      assign tw_idx[19:16] = 4'd0;
    end
  end

  assign bus.in_ready      = in_ready;
  assign bus.pipe_en       = adv;
  assign bus.bf_sel        = bf_sel;
  assign bus.tw_idx        = tw_idx;
  assign bus.out_valid     = out_valid;
  assign bus.start_sorting = out_valid & (ocnt == 5'd0);
  assign bus.frame_done    = out_valid & (ocnt == 5'd31);
  assign bus.busy          = (state != IDLE);
endmodule

// File: tb/tb_fft_ctrl.sv
// Scoreboard bench for fft_ctrl (STAGE_LAT=0, LAT=31): directed frames push expected
// output cycles/strobes; a negedge monitor pops and compares on every out_valid.
module tb_fft_ctrl;
  logic clk;
  logic rst;
  int   cyc;
  int   n_tests;
  int   n_fail;
  int   t0;

  fft_ctrl_if bus ();

  fft_ctrl #(.STAGE_LAT(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    int c;
    bit st;
    bit dn;
  } exp_t;
  exp_t exp_q[$];

  int          cnt_pts[6] = '{0, 5, 10, 16, 21, 27};
  logic [4:0]  bf_tab[6]  = '{5'b00000, 5'b10100, 5'b01010, 5'b00001, 5'b10101, 5'b11011};
  logic [19:0] tw_tab[6]  = '{20'h00000, 20'h080A5, 20'h0080A, 20'h00000, 20'h080A0, 20'h00C00};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, got, want, cyc);
    end
  endtask

  task automatic push(input int c, input bit st, input bit dn);
    exp_t e;
    e.c  = c;
    e.st = st;
    e.dn = dn;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals();
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_pipe_en", 32'(bus.pipe_en), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_start", 32'(bus.start_sorting), 32'd0);
    chk("rst_done", 32'(bus.frame_done), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_bf_sel", 32'(bus.bf_sel), 32'd0);
    chk("rst_tw_idx", 32'(bus.tw_idx), 32'd0);
  endtask

  // Leaves the bench at the start of a fresh cycle with the DUT idle.
  task automatic do_reset();
    bus.in_valid = 1'b0;
    rst = 1'b0;
    tick();
    tick();
    #2;
    chk_reset_vals();
    rst = 1'b1;
    tick();
  endtask

  task automatic drain_check();
    chk("sb_drain", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // Feeds n continuous samples; optionally asserts reset in the last feed cycle
  // so nothing flushes out after the directed window.
  task automatic feed(input int n, input bit rst_last);
    for (int i = 0; i < n; i++) begin
      bus.in_valid = 1'b1;
      if (rst_last && i == n - 1) rst = 1'b0;
      #2;
      tick();
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (bus.out_valid) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL out_seq: unexpected out_valid at cycle %0d", cyc);
      end else begin
        e = exp_q.pop_front();
        if (cyc != e.c || bus.start_sorting != e.st || bus.frame_done != e.dn) begin
          n_fail++;
          $display("FAIL out_seq: cycle %0d start %0b done %0b, expected cycle %0d start %0b done %0b",
                   cyc, bus.start_sorting, bus.frame_done, e.c, e.st, e.dn);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    bus.in_valid = 1'b0;
    rst = 1'b0;
    do_reset();

    // Continuous frame with stage select / twiddle checks at chosen cnt values.
    t0 = cyc;
`ifdef FFT_CTRL_FLUSH_EN
    for (int k = 0; k < 32; k++) push(t0 + 31 + k, k == 0, k == 31);
`else
    push(t0 + 31, 1'b1, 1'b0);
`endif
    for (int i = 0; i < 32; i++) begin
      bus.in_valid = 1'b1;
      #2;
      if (i == 3) chk("feed_pipe_en", 32'(bus.pipe_en), 32'd1);
      for (int p = 0; p < 6; p++) begin
        if (i == cnt_pts[p]) begin
          chk("bf_sel", 32'(bus.bf_sel), 32'(bf_tab[p]));
          chk("tw_idx", 32'(bus.tw_idx), 32'(tw_tab[p]));
        end
      end
      tick();
    end
    bus.in_valid = 1'b0;
`ifdef FFT_CTRL_FLUSH_EN
    for (int i = 32; i < 70; i++) begin
      #2;
      if (i == 32) chk("flush_first_adv", 32'(bus.pipe_en), 32'd1);
      if (i == 40) chk("flush_in_ready", 32'(bus.in_ready), 32'd0);
      if (i == 63) chk("flush_last_adv", 32'(bus.pipe_en), 32'd1);
      if (i == 64) begin
        chk("flush_stop", 32'(bus.pipe_en), 32'd0);
        chk("flush_busy64", 32'(bus.busy), 32'd1);
      end
      if (i == 65) chk("flush_busy65", 32'(bus.busy), 32'd0);
      tick();
    end
    drain_check();

    // Sample arrives mid-flush: held off until cnt wraps, then a new frame starts.
    do_reset();
    t0 = cyc;
    for (int k = 0; k < 32; k++) push(t0 + 31 + k, k == 0, k == 31);
    for (int k = 0; k < 32; k++) push(t0 + 95 + k, k == 0, k == 31);
    for (int i = 0; i < 140; i++) begin
      bus.in_valid = (i < 32) || (i >= 39 && i < 96);
      #2;
      if (i == 39) chk("mid_flush_ready39", 32'(bus.in_ready), 32'd0);
      if (i == 63) chk("mid_flush_ready63", 32'(bus.in_ready), 32'd0);
      if (i == 64) begin
        chk("mid_flush_ready64", 32'(bus.in_ready), 32'd1);
        chk("mid_flush_adv64", 32'(bus.pipe_en), 32'd1);
      end
      if (i == 65) chk("mid_flush_run", 32'(bus.in_ready), 32'd1);
      if (i == 128) chk("mid_flush_stop", 32'(bus.pipe_en), 32'd0);
      if (i == 129) chk("mid_flush_idle", 32'(bus.busy), 32'd0);
      tick();
    end
    drain_check();
`else
    for (int i = 32; i < 42; i++) begin
      #2;
      if (i == 32) begin
        chk("hold_busy", 32'(bus.busy), 32'd1);
        chk("hold_pipe_en", 32'(bus.pipe_en), 32'd0);
        chk("hold_in_ready", 32'(bus.in_ready), 32'd1);
      end
      if (i == 41) chk("hold_busy_end", 32'(bus.busy), 32'd1);
      tick();
    end
    for (int k = 1; k < 32; k++) push(t0 + 41 + k, 1'b0, k == 31);
    push(t0 + 73, 1'b1, 1'b0);
    feed(32, 1'b0);
    bus.in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #2;
      tick();
    end
    chk("nf_still_busy", 32'(bus.busy), 32'd1);
    drain_check();
`endif

    // Five-cycle input stall at cnt = 10.
    do_reset();
    t0 = cyc;
    for (int k = 0; k < 32; k++) push(t0 + 36 + k, k == 0, k == 31);
    push(t0 + 68, 1'b1, 1'b0);
    for (int i = 0; i < 37; i++) begin
      bus.in_valid = !(i >= 10 && i < 15);
      #2;
      if (i >= 10 && i < 15) begin
        chk("stall_pipe_en", 32'(bus.pipe_en), 32'd0);
        chk("stall_cnt_bf", 32'(bus.bf_sel), 32'(5'b01010));
      end
      if (i == 14) chk("stall_cnt_tw", 32'(bus.tw_idx), 32'h0080A);
      tick();
    end
    feed(32, 1'b1);
    do_reset();
    drain_check();

    // Three frames back to back, plus a fourth to push the third frame out.
    t0 = cyc;
    for (int j = 0; j < 97; j++) push(t0 + 31 + j, (j % 32) == 0, (j % 32) == 31);
    feed(128, 1'b1);
    do_reset();
    drain_check();

    // Reset at cnt = 20 of frame 2, then a clean frame must start sorting from ocnt 0.
    t0 = cyc;
    for (int j = 0; j < 21; j++) push(t0 + 31 + j, j == 0, 1'b0);
    feed(52, 1'b0);
    bus.in_valid = 1'b0;
    rst = 1'b0;
    #2;
    tick();
    #2;
    chk_reset_vals();
    rst = 1'b1;
    tick();
    t0 = cyc;
    push(t0 + 31, 1'b1, 1'b0);
    feed(32, 1'b1);
    do_reset();
    drain_check();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
